// File: rtl/acumulador_bcd_if.sv
// Keypad-to-accumulator bus: scanner key stream in, BCD entry and committed value out.
interface acumulador_bcd_if #(
    parameter int unsigned N_DIGITOS = 4,
    parameter int unsigned W_VALOR   = 14
) ();
    logic [3:0]             key_code;
    logic                   key_valid;
    logic [4*N_DIGITOS-1:0] digitos;
    logic [3:0]             num_digitos;
    logic                   ocupado;
    logic [W_VALOR-1:0]     valor;
    logic                   valor_valido;
    logic                   erro;

    // Scanner / consumer side
    modport master (
        output key_code,
        output key_valid,
        input  digitos,
        input  num_digitos,
        input  ocupado,
        input  valor,
        input  valor_valido,
        input  erro
    );

    // Accumulator side
    modport slave (
        input  key_code,
        input  key_valid,
        output digitos,
        output num_digitos,
        output ocupado,
        output valor,
        output valor_valido,
        output erro
    );
endinterface

// File: rtl/acumulador_bcd.sv
// Decimal entry accumulator: shifts key digits into a BCD buffer, '*' clears,
// '#' runs a digit-serial BCD-to-binary conversion and publishes the value.
module acumulador_bcd #(
    parameter int unsigned N_DIGITOS = 4,
    parameter int unsigned W_VALOR   = 14
) (
    input  logic             clk,
    input  logic             rst,
    acumulador_bcd_if.slave  bus
);
    localparam int unsigned W_DIG = 4 * N_DIGITOS;
    localparam int unsigned W_IDX = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [3:0]  TECLA_LIMPA    = 4'hE;
    localparam logic [3:0]  TECLA_CONFIRMA = 4'hF;
    localparam logic [3:0]  MAX_DIGITO     = 4'd9;

    typedef enum logic {ENTRADA, CONVERTE} estado_t;

    estado_t              state_q, state_d;
    logic                 key_valid_q;
    logic [W_DIG-1:0]     digitos_q, digitos_d;
    logic [3:0]           num_q, num_d;
    logic [W_IDX-1:0]     idx_q, idx_d;
    logic [W_VALOR-1:0]   acc_q, acc_d;
    logic [W_VALOR-1:0]   valor_q, valor_d;
    logic                 valor_valido_q, valor_valido_d;
    logic                 erro_q, erro_d;
    logic                 ocupado_q, ocupado_d;

    logic                 press_c;
    logic [3:0]           dig_sel_c;
    logic [W_VALOR-1:0]   acc_prox_c;

    // Rising edge of key_valid marks a new press
    assign press_c = bus.key_valid & ~key_valid_q;

    // Pick the BCD digit currently addressed by the conversion index
    always_comb begin
        dig_sel_c = 4'd0;
        for (int k = 0; k < int'(N_DIGITOS); k++) begin
            if (idx_q == W_IDX'(k)) begin
                dig_sel_c = digitos_q[4*k +: 4];
            end
        end
    end

    // acc*10 + digit, with *10 as shift-and-add truncated to the result width
    assign acc_prox_c = (acc_q << 3) + (acc_q << 1) + W_VALOR'(dig_sel_c);

    // Next-state and datapath decode
    always_comb begin
        state_d        = state_q;
        digitos_d      = digitos_q;
        num_d          = num_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        valor_d        = valor_q;
        valor_valido_d = 1'b0;
        erro_d         = 1'b0;

        case (state_q)
            ENTRADA: begin
                if (press_c) begin
                    if (bus.key_code <= MAX_DIGITO) begin
                        if (num_q < 4'(N_DIGITOS)) begin
                            digitos_d = (digitos_q << 4) | W_DIG'(bus.key_code);
                            num_d     = num_q + 4'd1;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end else if (bus.key_code == TECLA_LIMPA) begin
                        digitos_d = '0;
                        num_d     = 4'd0;
                    end else if (bus.key_code == TECLA_CONFIRMA) begin
                        if (num_q == 4'd0) begin
                            erro_d = 1'b1;
                        end else begin
                            acc_d   = '0;
                            idx_d   = W_IDX'(num_q - 4'd1);
                            state_d = CONVERTE;
                        end
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            CONVERTE: begin
                acc_d = acc_prox_c;
                if (idx_q == '0) begin
                    valor_d        = acc_prox_c;
                    valor_valido_d = 1'b1;
                    digitos_d      = '0;
                    num_d          = 4'd0;
                    state_d        = ENTRADA;
                end else begin
                    idx_d = idx_q - W_IDX'(1);
                end
            end
            default: state_d = ENTRADA;
        endcase

        ocupado_d = (state_d == CONVERTE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTRADA;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; key_valid_q resets high to ignore keys held through reset
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid_q    <= 1'b1;
            digitos_q      <= '0;
            num_q          <= 4'd0;
            idx_q          <= '0;
            acc_q          <= '0;
            valor_q        <= '0;
            valor_valido_q <= 1'b0;
            erro_q         <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            key_valid_q    <= bus.key_valid;
            digitos_q      <= digitos_d;
            num_q          <= num_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            valor_q        <= valor_d;
            valor_valido_q <= valor_valido_d;
            erro_q         <= erro_d;
            ocupado_q      <= ocupado_d;
        end
    end

    assign bus.digitos      = digitos_q;
    assign bus.num_digitos  = num_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.valor        = valor_q;
    assign bus.valor_valido = valor_valido_q;
    assign bus.erro         = erro_q;
endmodule

// File: tb/tb_acumulador_bcd.sv
// Bench for acumulador_bcd: directed scenarios plus random key streams against a queue-based model.
module tb_acumulador_bcd;
    localparam int unsigned N = 4;
    localparam int unsigned W = 14;

    logic clk;
    logic rst;

    acumulador_bcd_if #(.N_DIGITOS(N), .W_VALOR(W)) bus ();

    acumulador_bcd #(.N_DIGITOS(N), .W_VALOR(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: digits as a list (oldest first), conversion as a countdown
    int m_digs[$];
    int m_busy = 0;
    int m_pend = 0;
    int m_val  = 0;
    bit m_vv   = 1'b0;
    bit m_err  = 1'b0;
    bit m_kvq  = 1'b1;

    int div_cnt   = 0;
    int first_div = -1;
    int cyc       = 0;
    int n_err, n_vv, n_ocu, n_both;

    function automatic logic [4*N-1:0] m_pack();
        logic [4*N-1:0] r;
        int sz;
        r  = '0;
        sz = m_digs.size();
        for (int k = 0; k < sz; k++) r[4*k +: 4] = 4'(m_digs[sz-1-k]);
        return r;
    endfunction

    task automatic model_step();
        bit press;
        int kc;
        if (rst) begin
            m_digs.delete();
            m_busy = 0; m_val = 0; m_vv = 0; m_err = 0; m_kvq = 1;
        end else begin
            press = bus.key_valid && !m_kvq;
            m_kvq = bus.key_valid;
            kc    = int'(bus.key_code);
            m_vv  = 0;
            m_err = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_val = m_pend % (1 << W);
                    m_vv  = 1;
                    m_digs.delete();
                end
            end else if (press) begin
                if (kc <= 9) begin
                    if (m_digs.size() < int'(N)) m_digs.push_back(kc);
                    else m_err = 1;
                end else if (kc == 14) begin
                    m_digs.delete();
                end else if (kc == 15) begin
                    if (m_digs.size() == 0) m_err = 1;
                    else begin
                        m_pend = 0;
                        foreach (m_digs[k]) m_pend = m_pend * 10 + m_digs[k];
                        m_busy = m_digs.size();
                    end
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    // One clock: advance the model on the current inputs, then sample the DUT after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.digitos !== m_pack() || bus.num_digitos !== 4'(m_digs.size()) ||
            bus.ocupado !== (m_busy > 0) || bus.valor !== W'(m_val) ||
            bus.valor_valido !== m_vv || bus.erro !== m_err) begin
            if (div_cnt == 0) first_div = cyc;
            div_cnt++;
        end
        if (bus.erro === 1'b1) n_err++;
        if (bus.valor_valido === 1'b1) n_vv++;
        if (bus.ocupado === 1'b1) n_ocu++;
        if (bus.erro === 1'b1 && bus.valor_valido === 1'b1) n_both++;
    endtask

    task automatic clear_counts();
        n_err = 0; n_vv = 0; n_ocu = 0; n_both = 0;
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        repeat (hold) tick();
        bus.key_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // '#' press detected in cycle t; bit j of the masks is the output seen in cycle t+j
    task automatic commit(input int hold, output logic [15:0] ocu_m, output logic [15:0] vv_m);
        ocu_m = '0;
        vv_m  = '0;
        bus.key_code  = 4'hF;
        bus.key_valid = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            tick();
            ocu_m[j] = bus.ocupado;
            vv_m[j]  = bus.valor_valido;
            if (j >= hold) bus.key_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.digitos !== 16'h0) begin errors++; $display("FAIL reset_digitos: got %h expected 0000", bus.digitos); end
        checks++; if (bus.num_digitos !== 4'd0) begin errors++; $display("FAIL reset_num: got %0d expected 0", bus.num_digitos); end
        checks++; if (bus.valor !== 14'd0 || bus.valor_valido !== 1'b0) begin errors++; $display("FAIL reset_valor: got %0d/%b expected 0/0", bus.valor, bus.valor_valido); end
        checks++; if (bus.erro !== 1'b0 || bus.ocupado !== 1'b0) begin errors++; $display("FAIL reset_flags: got erro=%b ocupado=%b expected 0/0", bus.erro, bus.ocupado); end
    endtask

    task automatic test_basic();
        logic [15:0] om, vm;
        clear_counts();
        press(4'd1, 3, 2);
        press(4'd2, 3, 2);
        press(4'd3, 3, 2);
        checks++; if (bus.digitos !== 16'h0123) begin errors++; $display("FAIL basic_digitos: got %h expected 0123", bus.digitos); end
        checks++; if (bus.num_digitos !== 4'd3) begin errors++; $display("FAIL basic_num: got %0d expected 3", bus.num_digitos); end
        commit(3, om, vm);
        checks++; if (om !== 16'h000E) begin errors++; $display("FAIL basic_ocupado: got %h expected 000e", om); end
        checks++; if (vm !== 16'h0010) begin errors++; $display("FAIL basic_valido: got %h expected 0010", vm); end
        checks++; if (bus.valor !== 14'd123) begin errors++; $display("FAIL basic_valor: got %0d expected 123", bus.valor); end
        checks++; if (bus.digitos !== 16'h0 || bus.num_digitos !== 4'd0) begin errors++; $display("FAIL basic_cleared: got %h/%0d expected 0000/0", bus.digitos, bus.num_digitos); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL basic_erro: got %0d expected 0", n_err); end
    endtask

    task automatic test_buffer_full();
        logic [15:0] om, vm;
        repeat (4) press(4'd9, 3, 2);
        clear_counts();
        press(4'd5, 3, 2);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL full_erro_cycles: got %0d expected 1", n_err); end
        checks++; if (bus.digitos !== 16'h9999 || bus.num_digitos !== 4'd4) begin errors++; $display("FAIL full_buffer: got %h/%0d expected 9999/4", bus.digitos, bus.num_digitos); end
        commit(3, om, vm);
        checks++; if (om !== 16'h001E) begin errors++; $display("FAIL full_ocupado: got %h expected 001e", om); end
        checks++; if (vm !== 16'h0020) begin errors++; $display("FAIL full_valido: got %h expected 0020", vm); end
        checks++; if (bus.valor !== 14'd9999) begin errors++; $display("FAIL full_valor: got %0d expected 9999", bus.valor); end
    endtask

    task automatic test_rejected();
        clear_counts();
        press(4'hF, 3, 2);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL rej_hash_empty: got %0d erro cycles expected 1", n_err); end
        press(4'hB, 3, 2);
        checks++; if (n_err !== 2) begin errors++; $display("FAIL rej_letter: got %0d erro cycles expected 2", n_err); end
        checks++; if (n_vv !== 0 || n_ocu !== 0) begin errors++; $display("FAIL rej_no_convert: got vv=%0d ocupado=%0d expected 0/0", n_vv, n_ocu); end
    endtask

    task automatic test_held();
        clear_counts();
        press(4'd7, 20, 2);
        checks++; if (bus.num_digitos !== 4'd1 || bus.digitos !== 16'h0007) begin errors++; $display("FAIL held_once: got %h/%0d expected 0007/1", bus.digitos, bus.num_digitos); end
        bus.key_code  = 4'd3;
        bus.key_valid = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (bus.num_digitos !== 4'd0) begin errors++; $display("FAIL held_reset_release: got %0d expected 0", bus.num_digitos); end
        bus.key_valid = 1'b0;
        repeat (2) tick();
        press(4'd3, 3, 2);
        checks++; if (bus.num_digitos !== 4'd1 || bus.digitos !== 16'h0003) begin errors++; $display("FAIL held_next_edge: got %h/%0d expected 0003/1", bus.digitos, bus.num_digitos); end
    endtask

    task automatic test_clear_zero();
        logic [15:0] om, vm;
        clear_counts();
        press(4'd4, 3, 2);
        press(4'd7, 3, 2);
        press(4'hE, 3, 2);
        checks++; if (bus.digitos !== 16'h0 || bus.num_digitos !== 4'd0) begin errors++; $display("FAIL clear_buffer: got %h/%0d expected 0000/0", bus.digitos, bus.num_digitos); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL clear_erro: got %0d expected 0", n_err); end
        press(4'd0, 3, 2);
        checks++; if (bus.num_digitos !== 4'd1) begin errors++; $display("FAIL zero_num: got %0d expected 1", bus.num_digitos); end
        commit(3, om, vm);
        checks++; if (vm !== 16'h0004 || om !== 16'h0002) begin errors++; $display("FAIL zero_timing: got vv=%h ocu=%h expected 0004/0002", vm, om); end
        checks++; if (bus.valor !== 14'd0 || n_vv !== 1) begin errors++; $display("FAIL zero_valor: got %0d pulses=%0d expected 0/1", bus.valor, n_vv); end
    endtask

    task automatic test_reset_mid();
        press(4'd5, 3, 2); press(4'd6, 3, 2); press(4'd7, 3, 2); press(4'd8, 3, 2);
        clear_counts();
        bus.key_code  = 4'hF;
        bus.key_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        bus.key_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (n_ocu !== 2) begin errors++; $display("FAIL mid_ocupado_before_reset: got %0d expected 2", n_ocu); end
        checks++; if (n_vv !== 0 || bus.valor !== 14'd0) begin errors++; $display("FAIL mid_aborted: got pulses=%0d valor=%0d expected 0/0", n_vv, bus.valor); end
        checks++; if (bus.digitos !== 16'h0 || bus.num_digitos !== 4'd0 || bus.ocupado !== 1'b0 || bus.erro !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got %h/%0d/%b/%b expected 0000/0/0/0", bus.digitos, bus.num_digitos, bus.ocupado, bus.erro); end

        press(4'd5, 3, 2); press(4'd6, 3, 2); press(4'd7, 3, 2); press(4'd8, 3, 2);
        clear_counts();
        bus.key_code  = 4'hF;
        bus.key_valid = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 3) bus.key_valid = 1'b0;
            else if (j == 4) begin bus.key_code = 4'd2; bus.key_valid = 1'b1; end
            else if (j >= 9) bus.key_valid = 1'b0;
        end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL busy_press_erro: got %0d expected 0", n_err); end
        checks++; if (bus.valor !== 14'd5678 || n_vv !== 1) begin errors++; $display("FAIL busy_valor: got %0d pulses=%0d expected 5678/1", bus.valor, n_vv); end
        checks++; if (bus.num_digitos !== 4'd0) begin errors++; $display("FAIL busy_held_ignored: got %0d expected 0", bus.num_digitos); end
    endtask

    task automatic test_back_to_back();
        int r;
        clear_counts();
        press(4'd1, 1, 1);
        press(4'd2, 1, 1);
        press(4'd3, 1, 1);
        checks++; if (bus.digitos !== 16'h0123 || bus.num_digitos !== 4'd3) begin errors++; $display("FAIL b2b_digits: got %h/%0d expected 0123/3", bus.digitos, bus.num_digitos); end
        press(4'hE, 1, 1);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.key_valid = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       bus.key_code = 4'($urandom_range(0, 9));
            else if (r == 7) bus.key_code = 4'hF;
            else if (r == 8) bus.key_code = 4'hE;
            else             bus.key_code = 4'($urandom_range(10, 13));
            tick();
        end
        rst = 1'b0;
        bus.key_valid = 1'b0;
        repeat (10) tick();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL random_erro_with_valido: got %0d cycles expected 0", n_both); end
    endtask

    initial begin
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        test_reset();
        test_basic();
        test_buffer_full();
        test_rejected();
        test_held();
        test_clear_zero();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (div_cnt !== 0) begin
            errors++;
            $display("FAIL model_compare: got %0d divergent cycles (first at cycle %0d) expected 0", div_cnt, first_div);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
